// File: rtl/apb_pwm_arbiter.sv
// Two-requester round-robin APB master sharing one PWM slave.
// Runs SETUP/ACCESS with wait states and aborts a stalled ACCESS after TIMEOUT cycles.
module apb_pwm_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK_i,
  input  logic                    PRST_ni,
  input  logic [1:0]              req_i,
  input  logic [1:0]              we_i,
  input  logic [2*ADDR_WIDTH-1:0] addr_i,
  input  logic [2*DATA_WIDTH-1:0] wdata_i,
  output logic [1:0]              gnt_o,
  output logic [1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    PSEL_o,
  output logic                    PENABLE_o,
  output logic                    PWRITE_o,
  output logic [ADDR_WIDTH-1:0]   PADDR_o,
  output logic [DATA_WIDTH-1:0]   PWDATA_o,
  input  logic [DATA_WIDTH-1:0]   PRDATA_i,
  input  logic                    PREADY_i,
  input  logic                    PSLVERR_i
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  state_e                state_q;
  cmd_t                  cmd_q;
  cmd_t [1:0]            port_cmd;
  logic                  last_gnt_q, win_q, win_d;
  logic [CW-1:0]         wait_cnt_q;
  logic [1:0]            gnt_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q, psel_q, penable_q;
  logic                  timeout_hit;

  // Write data is masked at capture so PWDATA_o reads as 0 for reads.
  for (genvar k = 0; k < 2; k++) begin : g_port
    assign port_cmd[k].we    = we_i[k];
    assign port_cmd[k].addr  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign port_cmd[k].wdata = we_i[k] ? wdata_i[k*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_comb begin
    win_d = 1'b0;
    case (req_i)
      2'b10:   win_d = 1'b1;
      2'b11:   win_d = ~last_gnt_q;
      default: win_d = 1'b0;
    endcase
  end

  assign timeout_hit = TO_EN && (wait_cnt_q == TO_LAST);

  always_ff @(posedge PCLK_i or negedge PRST_ni) begin
    if (!PRST_ni) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      last_gnt_q <= 1'b1;
      win_q      <= 1'b0;
      wait_cnt_q <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_q        <= SETUP;
            win_q          <= win_d;
            last_gnt_q     <= win_d;
            cmd_q          <= port_cmd[win_d];
            gnt_q[win_d]   <= 1'b1;
            psel_q         <= 1'b1;
          end
        end
        SETUP: begin
          state_q    <= ACCESS;
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
        end
        ACCESS: begin
          // PREADY wins over a timeout landing in the same cycle.
          if (PREADY_i || timeout_hit) begin
            state_q         <= IDLE;
            psel_q          <= 1'b0;
            penable_q       <= 1'b0;
            cmd_q           <= '0;
            rvalid_q[win_q] <= 1'b1;
            rdata_q         <= (PREADY_i && !cmd_q.we) ? PRDATA_i : '0;
            err_q           <= PREADY_i ? PSLVERR_i : 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign PSEL_o    = psel_q;
  assign PENABLE_o = penable_q;
  assign PWRITE_o  = cmd_q.we;
  assign PADDR_o   = cmd_q.addr;
  assign PWDATA_o  = cmd_q.wdata;

endmodule

// File: tb/tb_apb_pwm_arbiter.sv
// Directed bench for apb_pwm_arbiter: expected responses queued at drive time,
// popped and compared when rvalid_o fires.
module tb_apb_pwm_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 16;

  logic          gclk = 1'b0;
  logic          grst_n = 1'b0;
  logic [1:0]    req_i = '0, we_i = '0;
  logic [2*AW-1:0] addr_i = '0;
  logic [2*DW-1:0] wdata_i = '0;
  logic [1:0]    gnt_o, rvalid_o;
  logic [DW-1:0] rdata_o, PWDATA_o, PRDATA_i = '0;
  logic          err_o, PSEL_o, PENABLE_o, PWRITE_o;
  logic [AW-1:0] PADDR_o;
  logic          PREADY_i = 1'b0, PSLVERR_i = 1'b0;

  apb_pwm_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .PCLK_i(gclk), .PRST_ni(grst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o), .PWRITE_o(PWRITE_o), .PADDR_o(PADDR_o),
    .PWDATA_o(PWDATA_o), .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i));

  always #5 gclk = ~gclk;

  typedef struct {
    int          port;
    logic [DW-1:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gnt"},     64'(gnt_o),     64'd0);
    chk({tag, ".rvalid"},  64'(rvalid_o),  64'd0);
    chk({tag, ".rdata"},   64'(rdata_o),   64'd0);
    chk({tag, ".err"},     64'(err_o),     64'd0);
    chk({tag, ".psel"},    64'(PSEL_o),    64'd0);
    chk({tag, ".penable"}, 64'(PENABLE_o), 64'd0);
    chk({tag, ".pwrite"},  64'(PWRITE_o),  64'd0);
    chk({tag, ".paddr"},   64'(PADDR_o),   64'd0);
    chk({tag, ".pwdata"},  64'(PWDATA_o),  64'd0);
  endtask

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    we_i[p] = we;
    addr_i[p*AW +: AW] = a;
    wdata_i[p*DW +: DW] = wd;
  endtask

  task automatic check_resp(input string tag);
    resp_t e;
    logic [1:0] oh;
    if (sb.size() == 0) begin
      chk({tag, ".unexpected_rvalid"}, 64'(rvalid_o), 64'd0);
    end else begin
      e = sb.pop_front();
      oh = 2'b01 << e.port;
      chk({tag, ".rvalid"}, 64'(rvalid_o), 64'(oh));
      chk({tag, ".rdata"},  64'(rdata_o),  64'(e.rdata));
      chk({tag, ".err"},    64'(err_o),    64'(e.err));
    end
  endtask

  // One transfer from cycle 0 (now) to response; slave stalls for `waits` ACCESS cycles.
  task automatic run_xfer(input string tag, input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int waits, input logic [DW-1:0] prd,
                          input logic slverr);
    resp_t e;
    bit    to;
    int    lat, cyc;
    logic [1:0]    oh;
    logic [DW-1:0] exp_pw;
    to  = (TO != 0) && (waits >= TO);
    lat = to ? 2 + TO : 3 + waits;
    oh  = 2'b01 << p;
    exp_pw = we ? wd : '0;
    e.port  = p;
    e.rdata = (to || we) ? '0 : prd;
    e.err   = to ? 1'b1 : slverr;
    sb.push_back(e);
    set_port(p, we, a, wd);
    req_i[p] = 1'b1;
    cyc = 0;
    forever begin
      @(posedge gclk); #1;
      cyc++;
      if (rvalid_o != 2'b00) begin
        chk({tag, ".latency"}, 64'(cyc), 64'(lat));
        check_resp(tag);
        chk({tag, ".idle_psel"},  64'(PSEL_o),  64'd0);
        chk({tag, ".idle_paddr"}, 64'(PADDR_o), 64'd0);
        PREADY_i = 1'b0; PSLVERR_i = 1'b0; PRDATA_i = '0;
        break;
      end
      if (cyc > 40) begin
        chk({tag, ".no_response"}, 64'(rvalid_o), 64'(oh));
        if (sb.size() > 0) void'(sb.pop_front());
        break;
      end
      if (cyc == 1) begin
        chk({tag, ".gnt"},     64'(gnt_o),     64'(oh));
        chk({tag, ".setup"},   64'({PSEL_o, PENABLE_o}), 64'b10);
        req_i[p] = 1'b0;
      end else begin
        chk({tag, ".access"},  64'({PSEL_o, PENABLE_o}), 64'b11);
        chk({tag, ".gnt_low"}, 64'(gnt_o), 64'd0);
        PREADY_i  = (cyc - 2 >= waits);
        // Garbage on the bus while not ready must never be sampled.
        PRDATA_i  = PREADY_i ? prd : ~prd;
        PSLVERR_i = PREADY_i ? slverr : 1'b1;
      end
      chk({tag, ".paddr"},  64'(PADDR_o),  64'(a));
      chk({tag, ".pwrite"}, 64'(PWRITE_o), 64'(we));
      chk({tag, ".pwdata"}, 64'(PWDATA_o), 64'(exp_pw));
    end
  endtask

  initial begin : main
    resp_t e;
    int    lastg, w, cyc;
    logic [AW-1:0] tie_addr [2];
    tie_addr[0] = 8'h10;
    tie_addr[1] = 8'h20;

    // Reset state
    repeat (2) @(posedge gclk);
    #1 chk_zero("reset");
    @(negedge gclk) grst_n = 1'b1;
    @(posedge gclk); #1;

    // Both requesting from reset: round-robin 0,1,0,1
    set_port(0, 1'b0, tie_addr[0], '0);
    set_port(1, 1'b0, tie_addr[1], '0);
    PREADY_i = 1'b1;
    PRDATA_i = 32'hA5A5_0001;
    req_i = 2'b11;
    lastg = 1;
    for (int t = 0; t < 4; t++) begin
      w = (lastg == 1) ? 0 : 1;
      cyc = 0;
      do begin @(posedge gclk); #1; cyc++; end while (gnt_o == 2'b00 && cyc < 6);
      chk("rr.gnt",   64'(gnt_o),   64'(2'b01 << w));
      chk("rr.paddr", 64'(PADDR_o), 64'(tie_addr[w]));
      e.port = w; e.rdata = PRDATA_i; e.err = 1'b0;
      sb.push_back(e);
      lastg = w;
      cyc = 0;
      do begin @(posedge gclk); #1; cyc++; end while (rvalid_o == 2'b00 && cyc < 6);
      if (t == 3) req_i = 2'b00;
      check_resp("rr");
    end
    PREADY_i = 1'b0;
    @(posedge gclk); #1;

    // Single read from requester 0
    run_xfer("rd0", 0, 1'b0, 8'h08, '0, 0, 32'h0000_00FF, 1'b0);
    // Write with three wait states from requester 1
    run_xfer("wr_wait", 1, 1'b1, 8'h04, 32'h0000_1234, 3, 32'hDEAD_BEEF, 1'b0);
    // Slave never ready: timeout abort
    run_xfer("timeout", 0, 1'b0, 8'h0C, '0, 1000, 32'h1111_2222, 1'b0);
    // Slave error on a read
    run_xfer("slverr", 1, 1'b0, 8'h14, '0, 1, 32'h3333_4444, 1'b1);
    // Back-to-back read with no wait
    run_xfer("rd1", 1, 1'b0, 8'h30, '0, 0, 32'hCAFE_F00D, 1'b0);

    // Reset mid-ACCESS during a requester-1 read
    set_port(1, 1'b0, 8'h40, '0);
    req_i = 2'b10;
    PREADY_i = 1'b0;
    @(posedge gclk); #1;
    req_i = 2'b00;
    @(posedge gclk); #1;
    @(posedge gclk); #1;
    chk("midrst.in_access", 64'({PSEL_o, PENABLE_o}), 64'b11);
    grst_n = 1'b0;
    #1 chk_zero("midrst");
    repeat (2) begin
      @(posedge gclk); #1;
      chk("midrst.hold_rvalid", 64'(rvalid_o), 64'd0);
    end
    @(negedge gclk) grst_n = 1'b1;
    @(posedge gclk); #1;

    // Tie after reset goes to requester 0
    set_port(0, 1'b0, 8'h50, '0);
    set_port(1, 1'b0, 8'h60, '0);
    req_i = 2'b11;
    PREADY_i = 1'b1;
    PRDATA_i = 32'h0BAD_F00D;
    @(posedge gclk); #1;
    chk("post_rst.gnt",   64'(gnt_o),   64'b01);
    chk("post_rst.paddr", 64'(PADDR_o), 64'h50);
    req_i = 2'b00;
    e.port = 0; e.rdata = 32'h0BAD_F00D; e.err = 1'b0;
    sb.push_back(e);
    cyc = 0;
    do begin @(posedge gclk); #1; cyc++; end while (rvalid_o == 2'b00 && cyc < 6);
    chk("post_rst.latency", 64'(cyc), 64'd2);
    check_resp("post_rst");
    PREADY_i = 1'b0;

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
